prog_loader_rom: RTL and testbench

//  Instruction-side responder for nanocpu: answers p_address with p_data from on-chip program RAM.

---
 rtl/nanocpu_pkg.sv | 14 +
 rtl/prog_ram.sv | 27 ++
 rtl/prog_loader_rom.sv | 125 ++++++++++++
 tb/tb_prog_loader_rom.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanocpu_pkg.sv
// Shared definitions for the nanocpu instruction-side blocks.
// Contains the loader state encoding and the instruction constants.
package nanocpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } ld_state_e;

endpackage

// File: rtl/prog_ram.sv
// Program memory: one synchronous write port and one asynchronous read port.
// The asynchronous read lets the CPU fetch path see its instruction in the same cycle.
module prog_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Contents are deliberately left untouched by reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader_rom.sv
// Instruction responder for nanocpu with a byte-serial program loader.
// Bytes arrive MSB-first, are packed into words and written sequentially from word 0.
module prog_loader_rom
    import nanocpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       p_address,
    output logic [DATA_W-1:0] p_data,
    input  logic              load_en,
    input  logic              ld_valid,
    input  logic [7:0]        ld_byte,
    output logic              ld_ready,
    output logic              ld_full,
    output logic [ADDR_W:0]   word_count
);

    localparam int DEPTH       = 2 ** ADDR_W;
    localparam int BYTES       = DATA_W / 8;
    localparam int BI_W        = $clog2(BYTES);
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(BYTES - 1);

    ld_state_e          state_q;
    logic [BI_W-1:0]    byte_idx_q;
    logic [ADDR_W-1:0]  wr_ptr_q;
    logic [ADDR_W:0]    word_count_q;
    logic               ld_full_q;
    logic               ld_ready_q;
    logic [DATA_W-1:0]  shift_q;

    logic [ADDR_W:0]    word_count_d;
    logic               ld_full_d;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_rdata;
    logic               addr_in_range;

    assign word_count_d = word_count_q + (ADDR_W+1)'(1);
    assign ld_full_d    = ld_full_q | (word_count_d == (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            byte_idx_q   <= '0;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            ld_full_q    <= 1'b0;
            ld_ready_q   <= 1'b0;
            shift_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_en) begin
                        state_q      <= FILL;
                        byte_idx_q   <= '0;
                        wr_ptr_q     <= '0;
                        word_count_q <= '0;
                        ld_full_q    <= 1'b0;
                        ld_ready_q   <= 1'b1;
                    end
                end
                FILL: begin
                    // Leaving LOAD drops any partially assembled word.
                    if (!load_en) begin
                        state_q    <= IDLE;
                        byte_idx_q <= '0;
                        ld_ready_q <= 1'b0;
                    end else if (ld_valid && ld_ready_q) begin
                        shift_q    <= {shift_q[DATA_W-9:0], ld_byte};
                        byte_idx_q <= byte_idx_q + BI_W'(1);
                        if (byte_idx_q == LAST_BYTE) begin
                            state_q    <= COMMIT;
                            ld_ready_q <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    // The write always completes, even if load_en has just dropped.
                    wr_ptr_q     <= wr_ptr_q + ADDR_W'(1);
                    word_count_q <= word_count_d;
                    byte_idx_q   <= '0;
                    ld_full_q    <= ld_full_d;
                    state_q      <= load_en ? FILL : IDLE;
                    ld_ready_q   <= load_en && !ld_full_d;
                end
                default: begin
                    state_q    <= IDLE;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_we = (state_q == COMMIT);

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock  (clock),
        .we     (ram_we),
        .waddr  (wr_ptr_q),
        .wdata  (shift_q),
        .raddr  (p_address[ADDR_W-1:0]),
        .rdata  (ram_rdata)
    );

    assign addr_in_range = (p_address[31:ADDR_W] == '0);

    // Fetches only see program memory in RUN mode with the loader idle.
    always_comb begin
        p_data = DATA_W'(NOP_INSTR);
        if (state_q == IDLE && !load_en && addr_in_range) begin
            p_data = ram_rdata;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign ld_full    = ld_full_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader_rom.sv
// Scoreboard bench for prog_loader_rom: stimulus queues expected values, a negedge monitor checks them.
// Two instances: ADDR_W=8 for the main scenarios and ADDR_W=2 for the full-memory scenario.
module tb_prog_loader_rom;

    localparam int K_PDATA = 0;
    localparam int K_WC    = 1;
    localparam int K_RDY   = 2;
    localparam int K_FULL  = 3;
    localparam int K_ACC   = 4;
    localparam int K_TO    = 5;

    typedef struct {
        int          kind;
        int          dut;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_p_address = '0;
    logic [31:0] a_p_data;
    logic        a_load_en = 1'b0;
    logic        a_ld_valid = 1'b0;
    logic [7:0]  a_ld_byte = '0;
    logic        a_ld_ready;
    logic        a_ld_full;
    logic [8:0]  a_word_count;

    logic [31:0] b_p_address = '0;
    logic [31:0] b_p_data;
    logic        b_load_en = 1'b0;
    logic        b_ld_valid = 1'b0;
    logic [7:0]  b_ld_byte = '0;
    logic        b_ld_ready;
    logic        b_ld_full;
    logic [2:0]  b_word_count;

    chk_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          b_acc = 0;
    int          to_cnt = 0;

    always #5 clk = ~clk;

    prog_loader_rom #(.ADDR_W(8), .DATA_W(32)) dut_a (
        .clock      (clk),
        .reset      (rst),
        .p_address  (a_p_address),
        .p_data     (a_p_data),
        .load_en    (a_load_en),
        .ld_valid   (a_ld_valid),
        .ld_byte    (a_ld_byte),
        .ld_ready   (a_ld_ready),
        .ld_full    (a_ld_full),
        .word_count (a_word_count)
    );

    prog_loader_rom #(.ADDR_W(2), .DATA_W(32)) dut_b (
        .clock      (clk),
        .reset      (rst),
        .p_address  (b_p_address),
        .p_data     (b_p_data),
        .load_en    (b_load_en),
        .ld_valid   (b_ld_valid),
        .ld_byte    (b_ld_byte),
        .ld_ready   (b_ld_ready),
        .ld_full    (b_ld_full),
        .word_count (b_word_count)
    );

    function automatic logic [31:0] observe(int kind, int dut);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_PDATA: v = (dut != 0) ? b_p_data : a_p_data;
            K_WC:    v = (dut != 0) ? 32'(b_word_count) : 32'(a_word_count);
            K_RDY:   v = (dut != 0) ? 32'(b_ld_ready) : 32'(a_ld_ready);
            K_FULL:  v = (dut != 0) ? 32'(b_ld_full) : 32'(a_ld_full);
            K_ACC:   v = 32'(b_acc);
            K_TO:    v = 32'(to_cnt);
            default: v = 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    // Monitor: every queued expectation is compared at the next falling edge.
    initial begin
        chk_t        e;
        logic [31:0] obs;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                obs = observe(e.kind, e.dut);
                total++;
                if (obs !== e.exp) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
                end else begin
                    $display("ok   %s: %h", e.name, obs);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_val(int kind, int dut, logic [31:0] v, string name);
        chk_t e;
        e.kind = kind;
        e.dut  = dut;
        e.exp  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic rd(int dut, logic [31:0] addr, logic [31:0] exp, string name);
        if (dut != 0) b_p_address = addr;
        else          a_p_address = addr;
        expect_val(K_PDATA, dut, exp, name);
        settle();
    endtask

    task automatic send_a(logic [7:0] b);
        bit ok;
        ok = 1'b0;
        a_ld_valid = 1'b1;
        a_ld_byte  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (a_ld_ready) ok = 1'b1;
            step();
        end
        a_ld_valid = 1'b0;
        total++;
        if (!ok) begin
            to_cnt++;
            bad++;
            $display("FAIL send_a: byte %h not accepted within 20 cycles", b);
        end else begin
            $display("ok   send_a: byte %h accepted", b);
        end
    endtask

    initial begin
        logic [7:0] t1 [8];
        logic [7:0] t3 [8];
        bit         rp [10];
        int         k;
        bit         acc;

        t1 = '{8'h60, 8'h85, 8'h00, 8'h00, 8'h04, 8'h85, 8'h30, 8'h00};
        t3 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        rp = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if (a_word_count !== '0 || a_ld_ready !== 1'b0 || a_ld_full !== 1'b0 || b_ld_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: wc=%h rdy=%b full=%b rdy_b=%b",
                     a_word_count, a_ld_ready, a_ld_full, b_ld_ready);
        end else begin
            $display("ok   reset_state");
        end
        expect_val(K_WC,   0, 32'd0, "reset_wc_a");
        expect_val(K_RDY,  0, 32'd0, "reset_rdy_a");
        expect_val(K_FULL, 0, 32'd0, "reset_full_a");
        expect_val(K_RDY,  1, 32'd0, "reset_rdy_b");
        settle();

        // Two words, then leave LOAD mode.
        a_load_en = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send_a(t1[i]);
        a_load_en = 1'b0;
        step();
        step();
        expect_val(K_WC, 0, 32'd2, "t1_wc");
        settle();
        rd(0, 32'd0, 32'h6085_0000, "t1_word0");
        rd(0, 32'd1, 32'h0485_3000, "t1_word1");

        // Abort a partial word.
        a_load_en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) send_a(8'hF0 + 8'(i));
        a_load_en = 1'b0;
        step();
        step();
        expect_val(K_WC, 0, 32'd0, "t2_wc");
        settle();
        rd(0, 32'd0, 32'h6085_0000, "t2_word0");
        rd(0, 32'd1, 32'h0485_3000, "t2_word1");

        // Continuous ld_valid: one stall cycle after every fourth byte.
        a_load_en = 1'b1;
        step();
        k = 0;
        for (int c = 0; c < 10; c++) begin
            a_ld_valid = 1'b1;
            a_ld_byte  = t3[(k > 7) ? 7 : k];
            expect_val(K_RDY, 0, 32'(rp[c]), $sformatf("t3_rdy_c%0d", c));
            settle();
            step();
            if (rp[c]) k++;
        end
        a_ld_valid = 1'b0;
        expect_val(K_WC, 0, 32'd2, "t3_wc_10cyc");
        settle();
        a_load_en = 1'b0;
        step();
        step();
        rd(0, 32'd0, 32'hDEAD_BEEF, "t3_word0");
        rd(0, 32'd1, 32'h1234_5678, "t3_word1");

        // Small memory: stream 20 bytes into 4 words.
        b_load_en = 1'b1;
        step();
        for (int c = 0; c < 30; c++) begin
            b_ld_valid = (b_acc < 20);
            b_ld_byte  = 8'(b_acc + 1);
            acc = b_ld_ready;
            step();
            if (acc && b_ld_valid) b_acc++;
        end
        b_ld_valid = 1'b0;
        expect_val(K_WC,   1, 32'd4,  "t4_wc");
        expect_val(K_FULL, 1, 32'd1,  "t4_full");
        expect_val(K_RDY,  1, 32'd0,  "t4_rdy");
        expect_val(K_ACC,  1, 32'd16, "t4_bytes_accepted");
        settle();
        b_load_en = 1'b0;
        step();
        step();
        expect_val(K_FULL, 1, 32'd1, "t4_full_run");
        settle();
        rd(1, 32'd0, 32'h0102_0304, "t4_word0");
        rd(1, 32'd3, 32'h0D0E_0F10, "t4_word3");
        rd(1, 32'd4, 32'h0000_0000, "t4_out_of_range");

        // Asynchronous reset in the middle of a word.
        a_load_en = 1'b1;
        step();
        send_a(8'h11);
        send_a(8'h22);
        send_a(8'h33);
        send_a(8'h44);
        send_a(8'hAA);
        expect_val(K_WC,  0, 32'd1, "t5_wc_before");
        expect_val(K_RDY, 0, 32'd1, "t5_rdy_before");
        settle();
        send_a(8'hBB);
        #1;
        rst       = 1'b1;
        a_load_en = 1'b0;
        expect_val(K_RDY,  0, 32'd0, "t5_rdy_after_rst");
        expect_val(K_WC,   0, 32'd0, "t5_wc_after_rst");
        expect_val(K_FULL, 1, 32'd0, "t5_full_b_after_rst");
        settle();
        rst = 1'b0;
        step();
        step();
        rd(0, 32'd0, 32'h1122_3344, "t5_word0");
        rd(0, 32'd1, 32'h1234_5678, "t5_word1");

        // Read gating.
        a_load_en = 1'b1;
        step();
        rd(0, 32'd0, 32'h0000_0000, "t6_fill_nop");
        a_load_en = 1'b0;
        step();
        step();
        rd(0, 32'h0000_0100, 32'h0000_0000, "t6_out_of_range");
        rd(0, 32'd0, 32'h1122_3344, "t6_in_range");

        expect_val(K_TO, 0, 32'd0, "handshake_timeouts");
        for (int i = 0; i < 10 && q.size() > 0; i++) settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
